// File: rtl/vdp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vdp_pkg
// Description : Shared constants and types for the VDP register-write transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package vdp_pkg;

    localparam int VDP_REG_NUM_W = 3;
    localparam int VDP_DATA_W    = 8;

    // Second control-port byte of a register write: bit 7 set, register number in the low bits.
    localparam logic [VDP_DATA_W-1:0] VDP_REG_WR_FLAG = 8'h80;

    // FIFO entry layout: {rd flag, register number, data byte}.
    localparam int c_REQ_W = 1 + VDP_REG_NUM_W + VDP_DATA_W;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_DATA = 3'd1;
    localparam logic [2:0] c_ST_GAP1 = 3'd2;
    localparam logic [2:0] c_ST_ADDR = 3'd3;
    localparam logic [2:0] c_ST_GAP2 = 3'd4;
    localparam logic [2:0] c_ST_READ = 3'd5;
    localparam logic [2:0] c_ST_CAPT = 3'd6;

    typedef struct packed {
        logic                     rd;
        logic [VDP_REG_NUM_W-1:0] regnum;
        logic [VDP_DATA_W-1:0]    data;
    } vdp_req_t;

    function automatic logic [VDP_DATA_W-1:0] vdp_addr_byte(input logic [VDP_REG_NUM_W-1:0] regnum);
        return VDP_REG_WR_FLAG | {{(VDP_DATA_W - VDP_REG_NUM_W){1'b0}}, regnum};
    endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vdp_req_fifo
// Description : Request FIFO; accepts a push while full when a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_req_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == c_FULL);
    assign w_pop    = pop && !empty;
    assign w_push   = push && (!full || w_pop);
    assign pop_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/vdp_reg_tx.sv
`default_nettype none
// ============================================================================
// Module      : vdp_reg_tx
// Description : Queues VDP register writes / status reads and issues control-port strobes.
//               Macro VDP_REG_TX_STATUS_EN builds the status-read path (READ/CAPT).
// Revision    : 1.0 - initial release
// ============================================================================
module vdp_reg_tx
    import vdp_pkg::*;
#(
    parameter int GAP        = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [VDP_REG_NUM_W-1:0] req_reg,
    input  logic [VDP_DATA_W-1:0]    req_data,
    input  logic                     req_rd,
    output logic                     wr_tick,
    output logic                     rd_tick,
    output logic [VDP_DATA_W-1:0]    dout,
    input  logic [VDP_DATA_W-1:0]    din,
    output logic [VDP_DATA_W-1:0]    status,
    output logic                     status_valid,
    output logic                     busy
);

    localparam int c_GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'((GAP > 0) ? GAP - 1 : 0);

    logic [2:0]               r_state;
    logic [2:0]               w_state_nxt;
    logic [c_GAP_W-1:0]       r_gap_cnt;
    logic [VDP_REG_NUM_W-1:0] r_reg;
    logic [VDP_DATA_W-1:0]    r_data;
    logic                     r_ready_en;

    logic                     w_dispatch;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic [c_REQ_W-1:0]       w_fifo_wdata;
    logic [c_REQ_W-1:0]       w_fifo_rdata;
    vdp_req_t                 w_head;
    logic                     w_in_gap;
    logic                     w_gap_done;

    // ------------------------------------------------------------------------
    // Request queue
    // ------------------------------------------------------------------------
    assign req_ready    = r_ready_en && (!w_fifo_full || w_pop);
    assign w_push       = req_valid && req_ready;
    assign w_fifo_wdata = {req_rd, req_reg, req_data};
    assign w_head       = w_fifo_rdata;

    vdp_req_fifo #(
        .WIDTH (c_REQ_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_fifo_wdata),
        .pop       (w_pop),
        .pop_data  (w_fifo_rdata),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Holds req_ready low through reset and releases it on the first clock afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    assign w_in_gap   = (r_state == c_ST_GAP1) || (r_state == c_ST_GAP2);
    assign w_gap_done = (r_gap_cnt == c_GAP_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_dispatch  = 1'b0;
        case (r_state)
            c_ST_IDLE: w_dispatch = 1'b1;
            c_ST_DATA: w_state_nxt = (GAP > 0) ? c_ST_GAP1 : c_ST_ADDR;
            c_ST_GAP1: begin
                if (w_gap_done) begin
                    w_state_nxt = c_ST_ADDR;
                end
            end
            c_ST_ADDR: begin
                if (GAP > 0) begin
                    w_state_nxt = c_ST_GAP2;
                end else begin
                    w_dispatch = 1'b1;
                end
            end
            c_ST_GAP2: begin
                if (w_gap_done) begin
                    w_dispatch = 1'b1;
                end
            end
`ifdef VDP_REG_TX_STATUS_EN
            c_ST_READ: w_state_nxt = c_ST_CAPT;
            c_ST_CAPT: begin
                if (GAP > 0) begin
                    w_state_nxt = c_ST_GAP2;
                end else begin
                    w_dispatch = 1'b1;
                end
            end
`endif
            default: w_state_nxt = c_ST_IDLE;
        endcase

        // Dispatch chains straight into the next request so GAP=0 traffic stays gapless.
        if (w_dispatch) begin
            if (w_fifo_empty) begin
                w_state_nxt = c_ST_IDLE;
            end else if (!w_head.rd) begin
                w_state_nxt = c_ST_DATA;
            end else begin
`ifdef VDP_REG_TX_STATUS_EN
                w_state_nxt = c_ST_READ;
`else
                w_state_nxt = c_ST_IDLE;
`endif
            end
        end
    end

    assign w_pop = w_dispatch && !w_fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
            r_reg   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_reg  <= w_head.regnum;
                r_data <= w_head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gap_cnt <= '0;
        end else if (w_in_gap && !w_gap_done) begin
            r_gap_cnt <= r_gap_cnt + c_GAP_W'(1);
        end else begin
            r_gap_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Control-port outputs
    // ------------------------------------------------------------------------
    assign wr_tick = (r_state == c_ST_DATA) || (r_state == c_ST_ADDR);
    assign busy    = (r_state != c_ST_IDLE) || !w_fifo_empty;

    always_comb begin
        dout = '0;
        case (r_state)
            c_ST_DATA: dout = r_data;
            c_ST_ADDR: dout = vdp_addr_byte(r_reg);
            default:   dout = '0;
        endcase
    end

`ifdef VDP_REG_TX_STATUS_EN
    logic [VDP_DATA_W-1:0] r_status;
    logic                  r_status_valid;

    assign rd_tick      = (r_state == c_ST_READ);
    assign status       = r_status;
    assign status_valid = r_status_valid;

    // din is taken at the end of CAPT, giving the VDP a full cycle after the read strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_status       <= '0;
            r_status_valid <= 1'b0;
        end else begin
            r_status_valid <= (r_state == c_ST_CAPT);
            if (r_state == c_ST_CAPT) begin
                r_status <= din;
            end
        end
    end
`else
    logic w_unused_din;

    assign w_unused_din = ^din;
    assign rd_tick      = 1'b0;
    assign status       = '0;
    assign status_valid = 1'b0;
`endif

endmodule
`default_nettype wire
